// File: rtl/i2s_pkg.sv
// Shared I2S constants and state encoding for the
// pcm_to_i2s transmitter and i2s_to_pcm receiver.
package i2s_pkg;

    localparam int I2S_NUMBER_OF_BITS = 8;
    localparam int I2S_SLOT_BITS      = 16;
    localparam int I2S_CLK_DIV        = 2;

    typedef enum logic {
        I2S_IDLE = 1'b0,
        I2S_RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/sck_divider.sv
// Bit-clock divider: toggles sck every CLK_DIV clk cycles
// and flags the sck falling edge as a one-cycle enable.
module sck_divider
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = I2S_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic sck_o,
    output logic fall_tick_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic          wrap;

    always_comb begin
        wrap  = (div_q == DIV_MAX);
        div_d = div_q;
        sck_d = sck_q;
        if (!run_i) begin
            div_d = '0;
            sck_d = 1'b0;
        end else if (wrap) begin
            div_d = '0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o       = sck_q;
    assign fall_tick_o = run_i && wrap && sck_q;

endmodule

// File: rtl/pcm_to_i2s.sv
// I2S master transmitter: double-buffered PCM pairs
// serialized MSB-first with the one-bit I2S delay.
module pcm_to_i2s
    import i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = I2S_NUMBER_OF_BITS,
    parameter int SLOT_BITS      = I2S_SLOT_BITS,
    parameter int CLK_DIV        = I2S_CLK_DIV
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [NUMBER_OF_BITS-1:0] sample_left,
    input  logic [NUMBER_OF_BITS-1:0] sample_right,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      frame_start,
    output logic                      underrun
);

    localparam int NB = NUMBER_OF_BITS;
    localparam int KW = $clog2(2 * SLOT_BITS);

    localparam logic [KW-1:0] K_LAST = KW'(2 * SLOT_BITS - 1);
    localparam logic [KW-1:0] K_SLOT = KW'(SLOT_BITS);
    localparam logic [KW-1:0] K_LHI  = KW'(NB);
    localparam logic [KW-1:0] K_RLO  = KW'(SLOT_BITS + 1);
    localparam logic [KW-1:0] K_RHI  = KW'(SLOT_BITS + NB);

    i2s_state_e state_q, state_d;

    logic [NB-1:0]   hold_l_q, hold_l_d;
    logic [NB-1:0]   hold_r_q, hold_r_d;
    logic            hold_valid_q, hold_valid_d;
    logic [2*NB-1:0] shift_q, shift_d;
    logic [KW-1:0]   k_q, k_d;
    logic            ws_q, ws_d;
    logic            sd_q, sd_d;
    logic            fs_q, fs_d;
    logic            ur_q, ur_d;

    logic run;
    logic fall_tick;
    logic load;
    logic xfer;

    sck_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .sck_o      (sck),
        .fall_tick_o(fall_tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            I2S_IDLE: if (ena)  state_d = I2S_RUN;
            I2S_RUN:  if (!ena) state_d = I2S_IDLE;
            default:            state_d = I2S_IDLE;
        endcase
    end

    assign run          = (state_q == I2S_RUN) && ena;
    assign load         = fall_tick && (k_q == K_LAST);
    assign sample_ready = !hold_valid_q || load;
    assign xfer         = sample_valid && sample_ready;

    // A transfer on a load cycle refills the slot the load just emptied.
    always_comb begin
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        hold_valid_d = hold_valid_q;
        if (xfer) begin
            hold_l_d     = sample_left;
            hold_r_d     = sample_right;
            hold_valid_d = 1'b1;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end
    end

    always_comb begin
        k_d     = k_q;
        ws_d    = ws_q;
        sd_d    = sd_q;
        shift_d = shift_q;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        if (!run) begin
            k_d     = K_LAST;
            ws_d    = 1'b0;
            sd_d    = 1'b0;
            shift_d = '0;
        end else if (fall_tick) begin
            k_d  = load ? '0 : k_q + 1'b1;
            ws_d = (k_d >= K_SLOT);
            sd_d = 1'b0;
            if (load) begin
                shift_d = hold_valid_q ? {hold_l_q, hold_r_q} : '0;
                fs_d    = 1'b1;
                ur_d    = !hold_valid_q;
            end else if ((k_d != '0 && k_d <= K_LHI) ||
                         (k_d >= K_RLO && k_d <= K_RHI)) begin
                sd_d    = shift_q[2*NB-1];
                shift_d = shift_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= I2S_IDLE;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            k_q          <= K_LAST;
            ws_q         <= 1'b0;
            sd_q         <= 1'b0;
            fs_q         <= 1'b0;
            ur_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            k_q          <= k_d;
            ws_q         <= ws_d;
            sd_q         <= sd_d;
            fs_q         <= fs_d;
            ur_q         <= ur_d;
        end
    end

    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule
